// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Brief    : Samples a binary count once per scan frame, converts it to BCD
//             with a sequential double-dabble engine and multiplexes the
//             decimal digits onto a common-anode, active-low 7-segment display.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DATA_W      = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     count,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam int c_BCD_W = 4 * NUM_DIGITS;

    localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_INIT = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_IDX_W-1:0]    r_dig_idx;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic                  w_tick;
    logic                  w_frame_tick;
    logic [DATA_W-1:0]     r_samp;
    logic [c_BCD_W-1:0]    r_bcd;
    logic [c_BCD_W-1:0]    w_bcd_adj;
    logic [c_CNT_W-1:0]    r_bitcnt;
    logic [c_BCD_W-1:0]    r_bcd_hold;
    logic                  r_valid_pend;
    logic [c_BCD_W-1:0]    r_disp_bcd;
    logic [c_BCD_W-1:0]    w_disp_nxt;
    logic [NUM_DIGITS:1]   w_hi_zero;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [3:0]            w_digit;
    logic                  w_sel_blank;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- scan timing
    assign w_tick       = (r_div == c_DIV_LAST);
    assign w_frame_tick = w_tick && (r_dig_idx == c_IDX_LAST);
    assign w_idx_nxt    = (r_dig_idx == c_IDX_LAST) ? '0 : r_dig_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_dig_idx <= '0;
        end else if (w_tick) begin
            r_div     <= '0;
            r_dig_idx <= w_idx_nxt;
        end else begin
            r_div     <= r_div + 1'b1;
        end
    end

    // ---------------------------------------------------------------- conversion FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_frame_tick) w_state_nxt = CONV;
            CONV:    if (r_bitcnt == c_CNT_ONE) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_samp     <= '0;
            r_bcd      <= '0;
            r_bitcnt   <= '0;
            r_bcd_hold <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_frame_tick) begin
                        r_samp   <= count;
                        r_bcd    <= '0;
                        r_bitcnt <= c_CNT_INIT;
                    end
                end
                CONV: begin
                    // MSB of the adjusted BCD falls off the top of the shift
                    {r_bcd, r_samp} <= {w_bcd_adj, r_samp} << 1;
                    r_bitcnt        <= r_bitcnt - 1'b1;
                end
                DONE: begin
                    r_bcd_hold <= r_bcd;
                end
                default: begin
                    r_bitcnt <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- display load
    assign w_disp_nxt = (w_frame_tick && r_valid_pend) ? r_bcd_hold : r_disp_bcd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_pend <= 1'b0;
            r_disp_bcd   <= '0;
        end else begin
            r_disp_bcd <= w_disp_nxt;
            if (r_state == DONE) begin
                r_valid_pend <= 1'b1;
            end else if (w_frame_tick) begin
                r_valid_pend <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- leading-zero blanking
    assign w_hi_zero[NUM_DIGITS] = 1'b1;
    assign w_blank[0]            = 1'b0;

    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_blank
        assign w_hi_zero[k] = w_hi_zero[k+1] && (w_disp_nxt[4*k +: 4] == 4'd0);
        assign w_blank[k]   = (BLANK_LZ != 0) && w_hi_zero[k];
    end

    always_comb begin
        w_digit     = '0;
        w_sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == c_IDX_W'(k)) begin
                w_digit     = w_disp_nxt[4*k +: 4];
                w_sel_blank = w_blank[k];
            end
        end
    end

    // Outputs are built from next-cycle index/data so they land with the new slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
        end else if (w_tick) begin
            if (w_sel_blank) begin
                r_an  <= '1;
                r_seg <= 7'h7F;
            end else begin
                r_an  <= ~(c_AN_ONE << w_idx_nxt);
                r_seg <= seg_decode(w_digit);
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Brief    : Scoreboard bench for seg7_scan_driver (short refresh divider).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic [3:0] count_nb;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an_nb;
    logic [6:0] seg_nb;
    logic       dp_nb;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    ecount   = 0;
    slot_t exp_q[$];

    logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    seg7_scan_driver #(.DATA_W(4), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .count(count), .an(an), .seg(seg), .dp(dp)
    );

    seg7_scan_driver #(.DATA_W(4), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .count(count_nb), .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) ecount <= 0;
        else      ecount <= ecount + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic slot_t model(input int value, input int k, input bit blz);
        slot_t s;
        int    p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (blz && k > 0 && value < p) begin
            s.an  = 4'hF;
            s.seg = 7'h7F;
        end else begin
            s.an    = 4'hF;
            s.an[k] = 1'b0;
            s.seg   = seg_tbl[(value / p) % 10];
        end
        return s;
    endfunction

    task automatic push_frame(input int value, input bit blz);
        for (int k = 0; k < 4; k++) exp_q.push_back(model(value, k, blz));
    endtask

    // Returns at the falling edge following rising edge e
    task automatic sync(input int e);
        int guard = 0;
        while (ecount < e && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (ecount != e) begin
            n_checks++;
            $display("FAIL sync: reached edge %0d, wanted edge %0d", ecount, e);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        count    = 4'd0;
        count_nb = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an !== 4'hF) $display("FAIL reset_an: got %h want f", an); else n_pass++;
        n_checks++;
        if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else n_pass++;
        n_checks++;
        if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else n_pass++;
        n_checks++;
        if ({an_nb, seg_nb, dp_nb} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL reset_nb: got %h/%h/%b want f/7f/1", an_nb, seg_nb, dp_nb);
        else n_pass++;
        rst = 1'b1;
        sync(1);
        n_checks++;
        if ({an, seg} !== {4'hF, 7'h7F}) $display("FAIL pre_tick1: got %h/%h want f/7f", an, seg);
        else n_pass++;
        sync(3);
        n_checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL pre_tick3: got %h/%h/%b want f/7f/1", an, seg, dp);
        else n_pass++;
    endtask

    task automatic test_count7();
        slot_t x;
        count = 4'd7;
        push_frame(7, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sync(32 + 4 * k);
            x = exp_q.pop_front();
            n_checks++;
            if ({an, seg} !== x)
                $display("FAIL count7_slot%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, x.an, x.seg);
            else n_pass++;
        end
    endtask

    task automatic test_count15();
        slot_t      x;
        logic [1:0] exp_st;
        count = 4'd15;
        push_frame(15, 1'b1);
        for (int e = 47; e <= 53; e++) begin
            sync(e);
            exp_st = (e == 47 || e == 53) ? 2'd0 : (e == 52) ? 2'd2 : 2'd1;
            n_checks++;
            if (dut.r_state !== exp_st)
                $display("FAIL conv_state_e%0d: got %0d want %0d", e, dut.r_state, exp_st);
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            sync(64 + 4 * k);
            x = exp_q.pop_front();
            n_checks++;
            if ({an, seg} !== x)
                $display("FAIL count15_slot%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, x.an, x.seg);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        slot_t x;
        count = 4'd9;
        push_frame(9, 1'b1);
        push_frame(9, 1'b1);
        for (int k = 0; k < 12; k++) begin
            sync(96 + 4 * k);
            x = exp_q.pop_front();
            n_checks++;
            if ({an, seg} !== x)
                $display("FAIL tear_e%0d: got an=%b seg=%b want an=%b seg=%b", 96 + 4 * k, an, seg, x.an, x.seg);
            else n_pass++;
            if (k == 1) begin
                count = 4'd10;
                push_frame(10, 1'b1);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        slot_t x;
        count = 4'd3;
        sync(145);
        n_checks++;
        if (dut.r_state !== 2'd1) $display("FAIL midconv_pre_state: got %0d want 1", dut.r_state);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL midconv_outputs: got %h/%h/%b want f/7f/1", an, seg, dp);
        else n_pass++;
        n_checks++;
        if (dut.r_state !== 2'd0 || dut.r_valid_pend !== 1'b0)
            $display("FAIL midconv_fsm: got state=%0d pend=%b want 0/0", dut.r_state, dut.r_valid_pend);
        else n_pass++;
        count = 4'd8;
        @(negedge clk);
        rst = 1'b1;
        sync(2);
        n_checks++;
        if ({an, seg} !== {4'hF, 7'h7F}) $display("FAIL midconv_rel: got %h/%h want f/7f", an, seg);
        else n_pass++;
        sync(16);
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b1000000})
            $display("FAIL midconv_zero: got %b/%b want 1110/1000000", an, seg);
        else n_pass++;
        push_frame(8, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sync(32 + 4 * k);
            x = exp_q.pop_front();
            n_checks++;
            if ({an, seg} !== x)
                $display("FAIL midconv_slot%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, x.an, x.seg);
            else n_pass++;
        end
    endtask

    task automatic test_no_blank();
        slot_t x;
        count_nb = 4'd0;
        push_frame(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sync(48 + 4 * k);
            x = exp_q.pop_front();
            n_checks++;
            if ({an_nb, seg_nb} !== x)
                $display("FAIL noblank_slot%0d: got an=%b seg=%b want an=%b seg=%b", k, an_nb, seg_nb, x.an, x.seg);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_count7();
        test_count15();
        test_back_to_back();
        test_reset_mid_conv();
        test_no_blank();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
